// File: rtl/carpma_hakemi.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters.
// A tag pipeline matched to GECIKME routes each result back to its owner.
`timescale 1ns/1ps
module carpma_hakemi #(
   parameter int unsigned GECIKME = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        istek0_gecerli_i,
   output logic        istek0_hazir_o,
   input  logic [1:0]  istek0_kontrol_i,
   input  logic [31:0] istek0_deger1_i,
   input  logic [31:0] istek0_deger2_i,
   input  logic        istek1_gecerli_i,
   output logic        istek1_hazir_o,
   input  logic [1:0]  istek1_kontrol_i,
   input  logic [31:0] istek1_deger1_i,
   input  logic [31:0] istek1_deger2_i,
   output logic        yanit0_gecerli_o,
   input  logic        yanit0_hazir_i,
   output logic [31:0] yanit0_sonuc_o,
   output logic        yanit1_gecerli_o,
   input  logic        yanit1_hazir_i,
   output logic [31:0] yanit1_sonuc_o,
   output logic        carpma_durdur_o,
   output logic [1:0]  carpma_kontrol_o,
   output logic [31:0] carpma_deger1_o,
   output logic [31:0] carpma_deger2_o,
   input  logic [31:0] carpma_sonuc_i
);
   localparam logic [1:0] CARPMA_MUL = 2'b00;

   // Index 0 is the head; index GECIKME-1 describes carpma_sonuc_i.
   logic [GECIKME-1:0] gecerli_q, gecerli_d;
   logic [GECIKME-1:0] sahip_q, sahip_d;
   logic               oncelik_q, oncelik_d;
   logic               tail_gecerli, tail_sahip, durdur;
   logic               iki_istek, grant0, grant1;

   assign tail_gecerli = gecerli_q[GECIKME-1];
   assign tail_sahip   = sahip_q[GECIKME-1];
   assign durdur       = tail_gecerli & ~(tail_sahip ? yanit1_hazir_i : yanit0_hazir_i);
   assign iki_istek    = istek0_gecerli_i & istek1_gecerli_i;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst_i && !durdur) begin
         if (iki_istek) begin
            grant0 = ~oncelik_q;
            grant1 = oncelik_q;
         end else begin
            grant0 = istek0_gecerli_i;
            grant1 = istek1_gecerli_i;
         end
      end
   end

   assign istek0_hazir_o   = grant0;
   assign istek1_hazir_o   = grant1;
   assign yanit0_gecerli_o = ~rst_i & tail_gecerli & ~tail_sahip;
   assign yanit1_gecerli_o = ~rst_i & tail_gecerli & tail_sahip;
   assign yanit0_sonuc_o   = carpma_sonuc_i;
   assign yanit1_sonuc_o   = carpma_sonuc_i;
   assign carpma_durdur_o  = ~rst_i & durdur;

   always_comb begin
      carpma_kontrol_o = CARPMA_MUL;
      carpma_deger1_o  = 32'd0;
      carpma_deger2_o  = 32'd0;
      if (grant0) begin
         carpma_kontrol_o = istek0_kontrol_i;
         carpma_deger1_o  = istek0_deger1_i;
         carpma_deger2_o  = istek0_deger2_i;
      end else if (grant1) begin
         carpma_kontrol_o = istek1_kontrol_i;
         carpma_deger1_o  = istek1_deger1_i;
         carpma_deger2_o  = istek1_deger2_i;
      end
   end

   always_comb begin
      gecerli_d = gecerli_q;
      sahip_d   = sahip_q;
      oncelik_d = oncelik_q;
      if (!durdur) begin
         for (int i = GECIKME - 1; i > 0; i--) begin
            gecerli_d[i] = gecerli_q[i-1];
            sahip_d[i]   = sahip_q[i-1];
         end
         gecerli_d[0] = grant0 | grant1;
         sahip_d[0]   = grant1;
         // A contested grant always happens when not stalled, so priority flips.
         if (iki_istek) oncelik_d = ~oncelik_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gecerli_q <= '0;
         sahip_q   <= '0;
         oncelik_q <= 1'b0;
      end else begin
         gecerli_q <= gecerli_d;
         sahip_q   <= sahip_d;
         oncelik_q <= oncelik_d;
      end
   end
endmodule

// File: tb/tb_carpma_hakemi.sv
// Directed bench for carpma_hakemi with a behavioural stallable multiplier.
`timescale 1ns/1ps
module tb_carpma_hakemi;
   localparam int unsigned LAT = 3;
   localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        istek0_gecerli, istek0_hazir, istek1_gecerli, istek1_hazir;
   logic [1:0]  istek0_kontrol, istek1_kontrol;
   logic [31:0] istek0_deger1, istek0_deger2, istek1_deger1, istek1_deger2;
   logic        yanit0_gecerli, yanit0_hazir, yanit1_gecerli, yanit1_hazir;
   logic [31:0] yanit0_sonuc, yanit1_sonuc;
   logic        carpma_durdur;
   logic [1:0]  carpma_kontrol;
   logic [31:0] carpma_deger1, carpma_deger2, carpma_sonuc;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   carpma_hakemi #(.GECIKME(LAT)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .istek0_gecerli_i (istek0_gecerli),
      .istek0_hazir_o   (istek0_hazir),
      .istek0_kontrol_i (istek0_kontrol),
      .istek0_deger1_i  (istek0_deger1),
      .istek0_deger2_i  (istek0_deger2),
      .istek1_gecerli_i (istek1_gecerli),
      .istek1_hazir_o   (istek1_hazir),
      .istek1_kontrol_i (istek1_kontrol),
      .istek1_deger1_i  (istek1_deger1),
      .istek1_deger2_i  (istek1_deger2),
      .yanit0_gecerli_o (yanit0_gecerli),
      .yanit0_hazir_i   (yanit0_hazir),
      .yanit0_sonuc_o   (yanit0_sonuc),
      .yanit1_gecerli_o (yanit1_gecerli),
      .yanit1_hazir_i   (yanit1_hazir),
      .yanit1_sonuc_o   (yanit1_sonuc),
      .carpma_durdur_o  (carpma_durdur),
      .carpma_kontrol_o (carpma_kontrol),
      .carpma_deger1_o  (carpma_deger1),
      .carpma_deger2_o  (carpma_deger2),
      .carpma_sonuc_i   (carpma_sonuc)
   );

   function automatic logic [31:0] mul_model(input logic [1:0] k, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (k)
         MUL:     begin p = ua * ub; return p[31:0];  end
         MULH:    begin p = sa * sb; return p[63:32]; end
         MULHSU:  begin p = sa * ub; return p[63:32]; end
         default: begin p = ua * ub; return p[63:32]; end
      endcase
   endfunction

   logic [31:0] m_pipe [LAT];
   always @(posedge clk) begin
      if (!carpma_durdur) begin
         m_pipe[0] <= mul_model(carpma_kontrol, carpma_deger1, carpma_deger2);
         for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
      end
   end
   assign carpma_sonuc = m_pipe[LAT-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic req0(input logic v, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] b);
      istek0_gecerli = v; istek0_kontrol = k; istek0_deger1 = a; istek0_deger2 = b;
   endtask

   task automatic req1(input logic v, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] b);
      istek1_gecerli = v; istek1_kontrol = k; istek1_deger1 = a; istek1_deger2 = b;
   endtask

   task automatic idle_all();
      req0(1'b0, MUL, 32'd0, 32'd0);
      req1(1'b0, MUL, 32'd0, 32'd0);
   endtask

   task automatic no_yanit(input string tag);
      check_eq({tag, "_y0v"}, yanit0_gecerli, 1'b0);
      check_eq({tag, "_y1v"}, yanit1_gecerli, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_all();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [1:0]  r0_k [4] = '{MULH, MUL, MUL, MUL};
   logic [31:0] r0_a [4] = '{32'h0011_0000, 32'd5, 32'd6, 32'd8};
   logic [31:0] r0_b [4] = '{32'h0003_0000, 32'd7, 32'd7, 32'd9};
   logic [31:0] r0_e [4] = '{32'd51, 32'd35, 32'd42, 32'd72};
   logic [1:0]  r1_k [4] = '{MUL, MUL, MULHU, MUL};
   logic [31:0] r1_a [4] = '{32'd2, 32'd4, 32'h0011_0000, 32'hFFFF_FFFF};
   logic [31:0] r1_b [4] = '{32'd3, 32'd4, 32'hFFFF_FFFF, 32'd2};
   logic [31:0] r1_e [4] = '{32'd6, 32'd16, 32'h0010_FFFF, 32'hFFFF_FFFE};

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int idx0, idx1, got0, got1, owner, k;
      rst = 1'b1;
      yanit0_hazir = 1'b1;
      yanit1_hazir = 1'b1;
      idle_all();

      // Outputs forced idle while reset is held, even with requests pending.
      @(negedge clk);
      req0(1'b1, MULH, 32'd121, 32'd70);
      req1(1'b1, MULHU, 32'd5, 32'd6);
      #1;
      check_eq("rst_hazir0", istek0_hazir, 1'b0);
      check_eq("rst_hazir1", istek1_hazir, 1'b0);
      check_eq("rst_durdur", carpma_durdur, 1'b0);
      check_eq("rst_kontrol", carpma_kontrol, MUL);
      check_eq("rst_deger1", carpma_deger1, 32'd0);
      check_eq("rst_deger2", carpma_deger2, 32'd0);
      no_yanit("rst");
      @(posedge clk);
      #1 rst = 1'b0;

      // Single MUL.
      @(negedge clk);
      req0(1'b1, MUL, 32'd121, 32'd70);
      req1(1'b0, MUL, 32'd0, 32'd0);
      #1;
      check_eq("single_hazir0", istek0_hazir, 1'b1);
      check_eq("single_hazir1", istek1_hazir, 1'b0);
      check_eq("single_deger1", carpma_deger1, 32'd121);
      check_eq("single_deger2", carpma_deger2, 32'd70);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         idle_all();
         #1;
         if (i == 3) begin
            check_eq("single_y0v", yanit0_gecerli, 1'b1);
            check_eq("single_sonuc", yanit0_sonuc, 32'd8470);
            check_eq("single_y1v", yanit1_gecerli, 1'b0);
         end else begin
            no_yanit("single_gap");
         end
      end

      // Simultaneous requests right after reset.
      do_reset();
      @(negedge clk);
      req0(1'b1, MUL, 32'd121, 32'hFFFF_FFBA);
      req1(1'b1, MULHU, 32'h0011_0000, 32'hFFFF_FFFF);
      #1;
      check_eq("sim_hazir0", istek0_hazir, 1'b1);
      check_eq("sim_hazir1", istek1_hazir, 1'b0);
      @(negedge clk);
      req0(1'b0, MUL, 32'd0, 32'd0);
      #1;
      check_eq("sim_hazir1_t1", istek1_hazir, 1'b1);
      check_eq("sim_kontrol_t1", carpma_kontrol, MULHU);
      @(negedge clk);
      idle_all();
      #1 no_yanit("sim_t2");
      @(negedge clk);
      #1;
      check_eq("sim_y0v", yanit0_gecerli, 1'b1);
      check_eq("sim_y0", yanit0_sonuc, 32'hFFFF_DEEA);
      check_eq("sim_y1v_t3", yanit1_gecerli, 1'b0);
      @(negedge clk);
      #1;
      check_eq("sim_y1v", yanit1_gecerli, 1'b1);
      check_eq("sim_y1", yanit1_sonuc, 32'h0010_FFFF);
      check_eq("sim_y0v_t4", yanit0_gecerli, 1'b0);
      @(negedge clk);
      #1 no_yanit("sim_t5");

      // Back-to-back fairness: both continuously valid for 8 cycles.
      do_reset();
      idx0 = 0; idx1 = 0; got0 = 0; got1 = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i < 8 && idx0 < 4) req0(1'b1, r0_k[idx0], r0_a[idx0], r0_b[idx0]);
         else req0(1'b0, MUL, 32'd0, 32'd0);
         if (i < 8 && idx1 < 4) req1(1'b1, r1_k[idx1], r1_a[idx1], r1_b[idx1]);
         else req1(1'b0, MUL, 32'd0, 32'd0);
         #1;
         if (i < 8) begin
            check_eq("fair_hazir0", istek0_hazir, (i % 2 == 0));
            check_eq("fair_hazir1", istek1_hazir, (i % 2 == 1));
         end
         if (i >= 3 && i < 11) begin
            owner = (i - 3) % 2;
            k = (i - 3) / 2;
            if (owner == 0) begin
               check_eq("fair_y0v", yanit0_gecerli, 1'b1);
               check_eq("fair_y0", yanit0_sonuc, r0_e[k]);
               check_eq("fair_y1v_off", yanit1_gecerli, 1'b0);
            end else begin
               check_eq("fair_y1v", yanit1_gecerli, 1'b1);
               check_eq("fair_y1", yanit1_sonuc, r1_e[k]);
               check_eq("fair_y0v_off", yanit0_gecerli, 1'b0);
            end
         end else begin
            no_yanit("fair_idle");
         end
         if (yanit0_gecerli) got0++;
         if (yanit1_gecerli) got1++;
         if (istek0_hazir) idx0++;
         if (istek1_hazir) idx1++;
      end
      check_eq("fair_count0", got0, 32'd4);
      check_eq("fair_count1", got1, 32'd4);

      // Response stall on requester 0 for three cycles.
      do_reset();
      @(negedge clk);
      req0(1'b1, MUL, 32'd121, 32'd70);
      #1 check_eq("stall_hazir0_t0", istek0_hazir, 1'b1);
      @(negedge clk);
      req0(1'b0, MUL, 32'd0, 32'd0);
      req1(1'b1, MUL, 32'd2, 32'd3);
      #1 check_eq("stall_hazir1_t1", istek1_hazir, 1'b1);
      @(negedge clk);
      idle_all();
      for (int i = 3; i <= 5; i++) begin
         @(negedge clk);
         yanit0_hazir = 1'b0;
         req1(1'b1, MUL, 32'd3, 32'd3);
         #1;
         check_eq("stall_durdur", carpma_durdur, 1'b1);
         check_eq("stall_hazir0", istek0_hazir, 1'b0);
         check_eq("stall_hazir1", istek1_hazir, 1'b0);
         check_eq("stall_y0v", yanit0_gecerli, 1'b1);
         check_eq("stall_y0", yanit0_sonuc, 32'd8470);
      end
      @(negedge clk);
      yanit0_hazir = 1'b1;
      #1;
      check_eq("stall_rel_durdur", carpma_durdur, 1'b0);
      check_eq("stall_rel_y0v", yanit0_gecerli, 1'b1);
      check_eq("stall_rel_y0", yanit0_sonuc, 32'd8470);
      check_eq("stall_rel_hazir1", istek1_hazir, 1'b1);
      @(negedge clk);
      idle_all();
      #1;
      check_eq("stall_next_y1v", yanit1_gecerli, 1'b1);
      check_eq("stall_next_y1", yanit1_sonuc, 32'd6);
      check_eq("stall_next_y0v", yanit0_gecerli, 1'b0);
      @(negedge clk);
      #1 no_yanit("stall_gap");
      @(negedge clk);
      #1;
      check_eq("stall_late_y1v", yanit1_gecerli, 1'b1);
      check_eq("stall_late_y1", yanit1_sonuc, 32'd9);

      // Reset mid-flight discards three in-flight ops and clears priority.
      do_reset();
      @(negedge clk);
      req0(1'b1, MUL, 32'd1, 32'd1);
      req1(1'b1, MUL, 32'd2, 32'd2);
      #1 check_eq("mid_hazir0_t0", istek0_hazir, 1'b1);
      @(negedge clk);
      req0(1'b1, MUL, 32'd3, 32'd3);
      #1 check_eq("mid_hazir1_t1", istek1_hazir, 1'b1);
      @(negedge clk);
      req1(1'b1, MUL, 32'd4, 32'd4);
      #1 check_eq("mid_hazir0_t2", istek0_hazir, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      idle_all();
      #1;
      no_yanit("mid_rst");
      check_eq("mid_rst_durdur", carpma_durdur, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req0(1'b1, MUL, 32'd5, 32'd6);
      req1(1'b1, MUL, 32'd7, 32'd7);
      #1;
      check_eq("mid_oncelik_h0", istek0_hazir, 1'b1);
      check_eq("mid_oncelik_h1", istek1_hazir, 1'b0);
      no_yanit("mid_t4");
      for (int i = 5; i <= 8; i++) begin
         @(negedge clk);
         idle_all();
         #1;
         if (i == 7) begin
            check_eq("mid_new_y0v", yanit0_gecerli, 1'b1);
            check_eq("mid_new_y0", yanit0_sonuc, 32'd30);
            check_eq("mid_new_y1v", yanit1_gecerli, 1'b0);
         end else begin
            no_yanit("mid_gap");
         end
      end

      // Idle bubbles between sparse requests.
      do_reset();
      @(negedge clk);
      req0(1'b1, MULHSU, 32'hFFFF_FFFF, 32'h0011_0000);
      #1 check_eq("bub_hazir0", istek0_hazir, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         idle_all();
         if (i == 5) req1(1'b1, MUL, 32'h10, 32'h10);
         #1;
         if (i == 3) begin
            check_eq("bub_y0v", yanit0_gecerli, 1'b1);
            check_eq("bub_y0", yanit0_sonuc, 32'hFFFF_FFFF);
            check_eq("bub_y1v_off", yanit1_gecerli, 1'b0);
         end else if (i == 8) begin
            check_eq("bub_y1v", yanit1_gecerli, 1'b1);
            check_eq("bub_y1", yanit1_sonuc, 32'd256);
            check_eq("bub_y0v_off", yanit0_gecerli, 1'b0);
         end else begin
            no_yanit("bub_gap");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
